// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared register-bus types, ASCII constants and hex decode helper
package bus_pkg;

    localparam int BUS_W = 16;

    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_W  = 8'h57;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        EOL,
        ISSUE,
        WAIT
    } init_state_t;

    // Returns {valid, nibble}; letters map via low nibble + 9 ('A'/'a' -> 10).
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_decoder.sv
// rtl/hex_decoder.sv - combinational ASCII byte to {is_hex, nibble}
module hex_decoder
    import bus_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o
);

    assign {is_hex_o, nibble_o} = hex_to_nibble(byte_i);

endmodule

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - ASCII command decoder and single-outstanding register bus master
module bus_initiator
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output logic [BUS_W-1:0] addr_o,
    output logic [BUS_W-1:0] wdata_o,
    output logic [BUS_W-1:0] rdata_o,
    output logic             rw_o,
    output logic             valid_o,
    input  logic [BUS_W-1:0] addr_i,
    input  logic [BUS_W-1:0] wdata_i,
    input  logic [BUS_W-1:0] rdata_i,
    input  logic             rw_i,
    input  logic             valid_i,
    output logic [BUS_W-1:0] resp_data_o,
    output logic             resp_rw_o,
    output logic             resp_timeout_o,
    output logic             resp_valid_o,
    output logic             err_o
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    // Counter hits 0 in the last WAIT cycle, so the timeout strobe lands TIMEOUT cycles after valid_o.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 2);

    init_state_t      state_q, state_d;
    logic             rw_q, rw_d;
    logic [1:0]       nib_cnt_q, nib_cnt_d;
    logic [BUS_W-1:0] addr_q, addr_d;
    logic [BUS_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BUS_W-1:0] addr_o_q, addr_o_d;
    logic [BUS_W-1:0] wdata_o_q, wdata_o_d;
    logic             rw_o_q, rw_o_d;
    logic             valid_o_q, valid_o_d;
    logic [BUS_W-1:0] resp_data_q, resp_data_d;
    logic             resp_rw_q, resp_rw_d;
    logic             resp_timeout_q, resp_timeout_d;
    logic             resp_valid_q, resp_valid_d;
    logic             err_q, err_d;

    logic             is_hex;
    logic [3:0]       nibble;
    logic             is_term;
    logic             byte_fire;
    logic             unused_return;

    hex_decoder u_hex_decoder (
        .byte_i   (byte_i),
        .is_hex_o (is_hex),
        .nibble_o (nibble)
    );

    // Return address/data are carried along the chain but deliberately not checked.
    assign unused_return = ^{addr_i, wdata_i};

    assign is_term   = (byte_i == CH_CR) || (byte_i == CH_LF);
    assign byte_ready_o = !rst && (state_q inside {IDLE, ADDR, DATA, EOL});
    assign byte_fire = byte_valid_i && byte_ready_o;

    always_comb begin
        state_d        = state_q;
        rw_d           = rw_q;
        nib_cnt_d      = nib_cnt_q;
        addr_d         = addr_q;
        data_d         = data_q;
        cnt_d          = cnt_q;
        addr_o_d       = addr_o_q;
        wdata_o_d      = wdata_o_q;
        rw_o_d         = rw_o_q;
        valid_o_d      = 1'b0;
        resp_data_d    = resp_data_q;
        resp_rw_d      = resp_rw_q;
        resp_timeout_d = resp_timeout_q;
        resp_valid_d   = 1'b0;
        err_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (byte_fire) begin
                    if (byte_i == CH_R || byte_i == CH_W) begin
                        rw_d      = (byte_i == CH_W);
                        nib_cnt_d = 2'd0;
                        state_d   = ADDR;
                    end else if (!is_term) begin
                        err_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (byte_fire) begin
                    if (is_hex) begin
                        addr_d    = {addr_q[BUS_W-5:0], nibble};
                        nib_cnt_d = nib_cnt_q + 2'd1;
                        if (nib_cnt_q == 2'd3) begin
                            state_d = rw_q ? DATA : EOL;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (byte_fire) begin
                    if (is_hex) begin
                        data_d    = {data_q[BUS_W-5:0], nibble};
                        nib_cnt_d = nib_cnt_q + 2'd1;
                        if (nib_cnt_q == 2'd3) begin
                            state_d = EOL;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            EOL: begin
                if (byte_fire) begin
                    if (is_term) begin
                        valid_o_d = 1'b1;
                        addr_o_d  = addr_q;
                        wdata_o_d = rw_q ? data_q : '0;
                        rw_o_d    = rw_q;
                        state_d   = ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                // A return in the same cycle the counter reaches 0 still wins over the timeout.
                if (valid_i) begin
                    resp_valid_d   = 1'b1;
                    resp_data_d    = rdata_i;
                    resp_rw_d      = rw_i;
                    resp_timeout_d = 1'b0;
                    state_d        = IDLE;
                end else if (cnt_q == '0) begin
                    resp_valid_d   = 1'b1;
                    resp_data_d    = '0;
                    resp_rw_d      = rw_q;
                    resp_timeout_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rw_q           <= 1'b0;
            nib_cnt_q      <= 2'd0;
            addr_q         <= '0;
            data_q         <= '0;
            cnt_q          <= '0;
            addr_o_q       <= '0;
            wdata_o_q      <= '0;
            rw_o_q         <= 1'b0;
            valid_o_q      <= 1'b0;
            resp_data_q    <= '0;
            resp_rw_q      <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_valid_q   <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            rw_q           <= rw_d;
            nib_cnt_q      <= nib_cnt_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            cnt_q          <= cnt_d;
            addr_o_q       <= addr_o_d;
            wdata_o_q      <= wdata_o_d;
            rw_o_q         <= rw_o_d;
            valid_o_q      <= valid_o_d;
            resp_data_q    <= resp_data_d;
            resp_rw_q      <= resp_rw_d;
            resp_timeout_q <= resp_timeout_d;
            resp_valid_q   <= resp_valid_d;
            err_q          <= err_d;
        end
    end

    assign addr_o         = addr_o_q;
    assign wdata_o        = wdata_o_q;
    assign rdata_o        = '0;
    assign rw_o           = rw_o_q;
    assign valid_o        = valid_o_q;
    assign resp_data_o    = resp_data_q;
    assign resp_rw_o      = resp_rw_q;
    assign resp_timeout_o = resp_timeout_q;
    assign resp_valid_o   = resp_valid_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - scoreboard bench for bus_initiator with a behavioural chain model
module tb_bus_initiator;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic [15:0] addr_o, wdata_o, rdata_o;
    logic        rw_o, valid_o;
    logic [15:0] addr_i, wdata_i, rdata_i;
    logic        rw_i, valid_i;
    logic [15:0] resp_data_o;
    logic        resp_rw_o, resp_timeout_o, resp_valid_o, err_o;

    always #5 clk = ~clk;

    bus_initiator #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .byte_i         (byte_i),
        .byte_valid_i   (byte_valid_i),
        .byte_ready_o   (byte_ready_o),
        .addr_o         (addr_o),
        .wdata_o        (wdata_o),
        .rdata_o        (rdata_o),
        .rw_o           (rw_o),
        .valid_o        (valid_o),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .rdata_i        (rdata_i),
        .rw_i           (rw_i),
        .valid_i        (valid_i),
        .resp_data_o    (resp_data_o),
        .resp_rw_o      (resp_rw_o),
        .resp_timeout_o (resp_timeout_o),
        .resp_valid_o   (resp_valid_o),
        .err_o          (err_o)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rw;
    } req_t;

    typedef struct packed {
        logic [15:0] data;
        logic        rw;
        logic        timeout;
    } resp_t;

    req_t        exp_req_q[$];
    resp_t       exp_resp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          err_seen = 0;
    int          err_exp = 0;
    int          err_chk_seq = 0;
    bit          chain_on = 1'b1;
    int          force_delay = -1;
    bit          stray_req = 1'b0;
    bit          done = 1'b0;
    logic [15:0] model_mem [int];
    logic [15:0] chain_mem [int];

    function automatic logic [7:0] hex_char(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + {4'b0, n};
        return (lower ? 8'h61 : 8'h41) + {4'b0, n} - 8'd10;
    endfunction

    // Chain model: remembers writes, answers reads, returns after a programmable delay.
    initial begin
        bit          pend;
        int          dly;
        logic [15:0] r_addr, r_wdata;
        logic        r_rw;
        pend = 1'b0; dly = 0; r_addr = '0; r_wdata = '0; r_rw = 1'b0;
        valid_i = 1'b0; addr_i = '0; wdata_i = '0; rdata_i = '0; rw_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else if (valid_o === 1'b1 && chain_on) begin
                pend    = 1'b1;
                dly     = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                r_addr  = addr_o;
                r_wdata = wdata_o;
                r_rw    = rw_o;
            end
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            if (stray_req) begin
                valid_i = 1'b1; rdata_i = 16'hDEAD; rw_i = 1'b1;
            end else if (pend) begin
                if (dly == 0) begin
                    pend    = 1'b0;
                    valid_i = 1'b1;
                    rw_i    = r_rw;
                    addr_i  = 16'($urandom);
                    wdata_i = 16'($urandom);
                    if (r_rw) begin
                        chain_mem[int'(r_addr)] = r_wdata;
                        rdata_i = '0;
                    end else begin
                        rdata_i = chain_mem.exists(int'(r_addr)) ? chain_mem[int'(r_addr)] : 16'h0;
                    end
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: the only process that compares and counts.
    initial begin
        int  cyc, req_cyc, last_seq;
        bit  in_flight, rst_prev, chk_ready_next;
        req_t  er;
        resp_t ep;
        cyc = 0; req_cyc = 0; last_seq = 0;
        in_flight = 0; rst_prev = 0; chk_ready_next = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("ready_in_rst", 96'(byte_ready_o), 96'(0));
                if (rst_prev)
                    chk("outputs_in_rst", 96'({addr_o, wdata_o, rdata_o, rw_o, valid_o,
                        resp_data_o, resp_rw_o, resp_timeout_o, resp_valid_o, err_o}), 96'(0));
                in_flight = 0;
                chk_ready_next = 0;
            end else begin
                if (rst_prev) chk("ready_after_rst", 96'(byte_ready_o), 96'(1));
                if (chk_ready_next) chk("ready_after_resp", 96'(byte_ready_o), 96'(1));
                chk_ready_next = 0;
                if (err_o === 1'b1) err_seen++;
                if (valid_o === 1'b1) begin
                    n_checks++;
                    if (exp_req_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_req: got addr=%h wdata=%h rw=%b, required no request",
                                 addr_o, wdata_o, rw_o);
                    end else begin
                        n_checks--;
                        er = exp_req_q.pop_front();
                        chk("request", 96'({addr_o, wdata_o, rw_o}), 96'(er));
                    end
                    in_flight = 1;
                    req_cyc = cyc;
                end
                if (resp_valid_o === 1'b1) begin
                    n_checks++;
                    if (exp_resp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_resp: got data=%h rw=%b timeout=%b, required no response",
                                 resp_data_o, resp_rw_o, resp_timeout_o);
                    end else begin
                        n_checks--;
                        ep = exp_resp_q.pop_front();
                        chk("response", 96'({resp_data_o, resp_rw_o, resp_timeout_o}), 96'(ep));
                        if (ep.timeout) chk("timeout_latency", 96'(cyc - req_cyc), 96'(TO));
                    end
                    in_flight = 0;
                    chk_ready_next = 1;
                end else if (in_flight) begin
                    chk("ready_in_wait", 96'(byte_ready_o), 96'(0));
                    if (cyc - req_cyc > 40) begin
                        chk("response_watchdog", 96'(cyc - req_cyc), 96'(TO));
                        in_flight = 0;
                    end
                end
                if (err_chk_seq != last_seq) begin
                    last_seq = err_chk_seq;
                    chk("err_count", 96'(err_seen), 96'(err_exp));
                end
            end
            rst_prev = rst;
            if (done || cyc > 60000) begin
                if (cyc > 60000) chk("global_time_limit", 96'(cyc), 96'(60000));
                chk("req_queue_empty", 96'(exp_req_q.size()), 96'(0));
                chk("resp_queue_empty", 96'(exp_resp_q.size()), 96'(0));
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_i = b;
        byte_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (byte_ready_o === 1'b1) break;
        end
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic settle();
        for (int i = 0; i < 60 && exp_resp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        err_chk_seq++;
        @(posedge clk);
        #1;
    endtask

    // Builds the command text from fields; mask bit i selects lowercase for hex digit i.
    task automatic build_cmd(input bit rw, input logic [15:0] a, input logic [15:0] d,
                             input logic [7:0] mask, input bit use_cr, input bit crlf,
                             output logic [7:0] bq[$]);
        logic [31:0] digits;
        int nd;
        bq = {};
        bq.push_back(rw ? 8'h57 : 8'h52);
        digits = {a, d};
        nd = rw ? 8 : 4;
        for (int i = 0; i < nd; i++) bq.push_back(hex_char(digits[31 - 4*i -: 4], mask[i]));
        bq.push_back(use_cr ? 8'h0D : 8'h0A);
        if (use_cr && crlf) bq.push_back(8'h0A);
    endtask

    task automatic issue(input bit rw, input logic [15:0] a, input logic [15:0] d,
                         input logic [7:0] mask, input bit use_cr, input bit crlf,
                         input bit expect_resp);
        logic [7:0] bq[$];
        resp_t r;
        build_cmd(rw, a, d, mask, use_cr, crlf, bq);
        exp_req_q.push_back('{addr: a, wdata: rw ? d : 16'h0, rw: rw});
        if (expect_resp) begin
            if (chain_on) begin
                r = '{data: rw ? 16'h0 : (model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'h0),
                      rw: rw, timeout: 1'b0};
                if (rw) model_mem[int'(a)] = d;
            end else begin
                r = '{data: 16'h0, rw: rw, timeout: 1'b1};
            end
            exp_resp_q.push_back(r);
        end
        foreach (bq[i]) send_byte(bq[i]);
    endtask

    task automatic malformed();
        logic [7:0] bq[$];
        logic [7:0] bad;
        bit rw;
        int p, last;
        rw = 1'($urandom);
        build_cmd(rw, 16'($urandom), 16'($urandom), 8'($urandom), 1'b0, 1'b0, bq);
        last = bq.size() - 1;
        p = $urandom_range(0, last);
        case ($urandom_range(0, 1))
            0:       bad = (p == 0) ? 8'h58 : (p == last) ? 8'h37 : 8'h47;
            default: bad = (p == 0) ? 8'h72 : (p == last) ? 8'h51 : 8'h7A;
        endcase
        for (int i = 0; i < p; i++) send_byte(bq[i]);
        send_byte(bad);
        err_exp++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        issue(1'b1, 16'h0003, 16'h1234, 8'h00, 1'b0, 1'b0, 1'b1);
        settle();
        issue(1'b0, 16'h0003, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1);
        settle();

        send_str("w00ffabcd\n");
        err_exp += 9;
        settle();
        issue(1'b1, 16'h00FF, 16'hABCD, 8'hF0, 1'b0, 1'b0, 1'b1);
        settle();
        issue(1'b0, 16'h00FF, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        settle();

        send_str("R00G1\n");
        err_exp += 2;
        settle();
        issue(1'b0, 16'h0003, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1);
        settle();

        // Latest return that still counts as success.
        force_delay = TO - 2;
        issue(1'b0, 16'h00FF, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        settle();
        force_delay = -1;

        chain_on = 1'b0;
        issue(1'b1, 16'h0042, 16'h5555, 8'h00, 1'b0, 1'b0, 1'b1);
        settle();

        issue(1'b0, 16'h0003, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        stray_req = 1'b1;
        @(negedge clk);
        stray_req = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chain_on = 1'b1;
        settle();
        issue(1'b0, 16'h0003, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        settle();

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                malformed();
            end else begin
                chain_on = ($urandom_range(0, 7) != 0);
                force_delay = $urandom_range(0, TO - 2);
                if ($urandom_range(0, 3) == 0) send_byte(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
                issue(1'($urandom), 16'($urandom_range(0, 7)), 16'($urandom), 8'($urandom),
                      1'($urandom), 1'($urandom), 1'b1);
            end
            settle();
        end
        chain_on = 1'b1;
        force_delay = -1;

        done = 1'b1;
        forever @(posedge clk);
    end

endmodule
